// File: rtl/engine_sample_sequencer_pkg.sv
// Shared definitions for the engine sample sequencer: FSM state constants
// and small helpers used by the sequencer and its watchdog.
package engine_sample_sequencer_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    localparam logic [SEQ_STATE_W-1:0] ENGINE_SEQ_STATE_IDLE   = 3'd0;
    localparam logic [SEQ_STATE_W-1:0] ENGINE_SEQ_STATE_GAIN   = 3'd1;
    localparam logic [SEQ_STATE_W-1:0] ENGINE_SEQ_STATE_SETTLE = 3'd2;
    localparam logic [SEQ_STATE_W-1:0] ENGINE_SEQ_STATE_WAIT   = 3'd3;
    localparam logic [SEQ_STATE_W-1:0] ENGINE_SEQ_STATE_MIX    = 3'd4;

    // States in which the sequencer waits on an external responder
    function automatic logic is_watched_state(input logic [SEQ_STATE_W-1:0] s);
        return (s == ENGINE_SEQ_STATE_GAIN) ||
               (s == ENGINE_SEQ_STATE_WAIT) ||
               (s == ENGINE_SEQ_STATE_MIX);
    endfunction

endpackage

// File: rtl/engine_sample_sequencer_seq_watchdog.sv
// seq_watchdog: loadable cycle counter with a terminal-count strobe.
// The count restarts from zero whenever load is high or en is low; the
// strobe is raised combinationally on the cycle the count reaches its limit.
module seq_watchdog #(
    parameter int unsigned timeout_cycles = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(timeout_cycles + 1);

    logic [CNT_W-1:0] cnt;

    // Cycle counter, restarted on every load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load || !en) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired_c = en && (cnt == CNT_W'(timeout_cycles - 1));

endmodule

// File: rtl/engine_sample_sequencer.sv
// engine_sample_sequencer: steps one audio sample at a time through the
// input gain stage, the active DSP pipelines and the output mixer, with
// per-pipeline masking, sample/overrun statistics and an optional stall
// watchdog enabled by ENGINE_SEQ_WATCHDOG_EN.
module engine_sample_sequencer
    import engine_sample_sequencer_pkg::*;
#(
    parameter int unsigned data_width     = 16,
    parameter int unsigned n_pipelines    = 2,
    parameter int unsigned counter_width  = 32,
    parameter int unsigned timeout_cycles = 4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [data_width-1:0]    in_sample,
    input  logic                     sample_ready,
    output logic [data_width-1:0]    gain_sample,
    output logic                     gain_req,
    input  logic                     gain_done,
    output logic                     pipe_tick,
    input  logic [n_pipelines-1:0]   pipe_ready,
    input  logic [n_pipelines-1:0]   pipe_active,
    output logic                     mix_req,
    input  logic                     mix_done,
    input  logic [data_width-1:0]    mix_sample,
    output logic [data_width-1:0]    out_sample,
    output logic                     out_valid,
    output logic                     ready,
    input  logic                     clear_stats,
    output logic [counter_width-1:0] sample_count,
    output logic [counter_width-1:0] overrun_count,
    output logic                     timeout,
    output logic [n_pipelines-1:0]   timed_out_mask
);

    if (n_pipelines < 1 || n_pipelines > 16 || timeout_cycles < 2) begin : g_param_check
        $error("engine_sample_sequencer: illegal parameter value");
    end

    logic [SEQ_STATE_W-1:0] state;
    logic [SEQ_STATE_W-1:0] state_d;
    logic [data_width-1:0]  gain_sample_d;
    logic [data_width-1:0]  out_sample_d;
    logic [n_pipelines-1:0] timed_out_mask_d;
    logic                   gain_req_d;
    logic                   pipe_tick_d;
    logic                   mix_req_d;
    logic                   out_valid_d;
    logic                   ready_d;
    logic                   timeout_d;
    logic                   sample_inc_c;
    logic                   overrun_c;
    logic                   pipes_done_c;
    logic                   wd_expired_c;

    assign pipes_done_c = &(pipe_ready | ~pipe_active);
    assign overrun_c    = sample_ready && (state != ENGINE_SEQ_STATE_IDLE);

`ifdef ENGINE_SEQ_WATCHDOG_EN
    logic wd_load_c;

    // Watchdog restarts on every state change
    assign wd_load_c = (state_d != state);

    seq_watchdog #(
        .timeout_cycles(timeout_cycles)
    ) u_seq_watchdog (
        .clk       (clk),
        .reset     (reset),
        .load      (wd_load_c),
        .en        (is_watched_state(state)),
        .expired_c (wd_expired_c)
    );
`else
    assign wd_expired_c = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ENGINE_SEQ_STATE_IDLE;
            gain_sample    <= '0;
            gain_req       <= 1'b0;
            pipe_tick      <= 1'b0;
            mix_req        <= 1'b0;
            out_sample     <= '0;
            out_valid      <= 1'b0;
            ready          <= 1'b1;
            timeout        <= 1'b0;
            timed_out_mask <= '0;
        end else begin
            state          <= state_d;
            gain_sample    <= gain_sample_d;
            gain_req       <= gain_req_d;
            pipe_tick      <= pipe_tick_d;
            mix_req        <= mix_req_d;
            out_sample     <= out_sample_d;
            out_valid      <= out_valid_d;
            ready          <= ready_d;
            timeout        <= timeout_d;
            timed_out_mask <= timed_out_mask_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d          = state;
        gain_sample_d    = gain_sample;
        out_sample_d     = out_sample;
        timed_out_mask_d = timed_out_mask;
        gain_req_d       = 1'b0;
        pipe_tick_d      = 1'b0;
        mix_req_d        = 1'b0;
        out_valid_d      = 1'b0;
        timeout_d        = 1'b0;
        sample_inc_c     = 1'b0;

        case (state)
            ENGINE_SEQ_STATE_IDLE: begin
                if (sample_ready) begin
                    gain_sample_d = in_sample;
                    gain_req_d    = 1'b1;
                    state_d       = ENGINE_SEQ_STATE_GAIN;
                end
            end
            ENGINE_SEQ_STATE_GAIN: begin
                if (gain_done) begin
                    pipe_tick_d  = 1'b1;
                    sample_inc_c = 1'b1;
                    state_d      = ENGINE_SEQ_STATE_SETTLE;
                end else if (wd_expired_c) begin
                    timeout_d        = 1'b1;
                    timed_out_mask_d = '0;
                    state_d          = ENGINE_SEQ_STATE_IDLE;
                end
            end
            ENGINE_SEQ_STATE_SETTLE: begin
                // one dead cycle so pipelines can drop their ready flags
                state_d = ENGINE_SEQ_STATE_WAIT;
            end
            ENGINE_SEQ_STATE_WAIT: begin
                if (pipes_done_c) begin
                    mix_req_d = 1'b1;
                    state_d   = ENGINE_SEQ_STATE_MIX;
                end else if (wd_expired_c) begin
                    timeout_d        = 1'b1;
                    timed_out_mask_d = pipe_active & ~pipe_ready;
                    mix_req_d        = 1'b1;
                    state_d          = ENGINE_SEQ_STATE_MIX;
                end
            end
            ENGINE_SEQ_STATE_MIX: begin
                if (mix_done) begin
                    out_sample_d = mix_sample;
                    out_valid_d  = 1'b1;
                    state_d      = ENGINE_SEQ_STATE_IDLE;
                end else if (wd_expired_c) begin
                    timeout_d        = 1'b1;
                    timed_out_mask_d = '0;
                    state_d          = ENGINE_SEQ_STATE_IDLE;
                end
            end
            default: begin
                state_d = ENGINE_SEQ_STATE_IDLE;
            end
        endcase

        ready_d = (state_d == ENGINE_SEQ_STATE_IDLE);
    end

    // Dispatched-sample counter, wraps; clear has priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_count <= '0;
        end else if (clear_stats) begin
            sample_count <= '0;
        end else if (sample_inc_c) begin
            sample_count <= sample_count + counter_width'(1);
        end
    end

    // Dropped-sample counter, saturates; clear has priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun_count <= '0;
        end else if (clear_stats) begin
            overrun_count <= '0;
        end else if (overrun_c && (overrun_count != {counter_width{1'b1}})) begin
            overrun_count <= overrun_count + counter_width'(1);
        end
    end

endmodule

// File: tb/tb_engine_sample_sequencer.sv
// Self-checking bench for engine_sample_sequencer. Responders for the gain
// stage, pipelines and mixer react to the sequencer's strobes with
// configurable latencies; a transaction-level model predicts acceptance,
// counters and completed outputs. Watchdog checks follow ENGINE_SEQ_WATCHDOG_EN.
module tb_engine_sample_sequencer;

    localparam int unsigned DW   = 16;
    localparam int unsigned NP   = 4;
    localparam int unsigned CW   = 4;
    localparam int unsigned TO   = 16;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_sample = '0;
    logic          sample_ready = 1'b0;
    logic [DW-1:0] gain_sample;
    logic          gain_req;
    logic          gain_done = 1'b0;
    logic          pipe_tick;
    logic [NP-1:0] pipe_ready = '1;
    logic [NP-1:0] pipe_active = '1;
    logic          mix_req;
    logic          mix_done = 1'b0;
    logic [DW-1:0] mix_sample = '0;
    logic [DW-1:0] out_sample;
    logic          out_valid;
    logic          ready;
    logic          clear_stats = 1'b0;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] overrun_count;
    logic          timeout;
    logic [NP-1:0] timed_out_mask;

    int vectors = 0;
    int errors  = 0;

    // responder configuration and state
    int            gain_lat = 1, mix_lat = 1, gain_wait = 0, mix_wait = 0;
    int            pipe_lat [NP];
    int            pipe_busy[NP];
    logic [NP-1:0] pipe_stuck = '0;
    logic          spur = 1'b0;
    logic          sr_with_mix = 1'b0;
    logic [DW-1:0] next_mix = '0;

    // reference model
    bit            m_busy = 0, m_gained = 0, exp_gain_req = 0, exp_out_valid = 0;
    int            m_samples = 0, m_ovr = 0;
    logic [DW-1:0] m_out = '0, m_in = '0;

    engine_sample_sequencer #(
        .data_width(DW), .n_pipelines(NP), .counter_width(CW), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .reset(reset), .in_sample(in_sample), .sample_ready(sample_ready),
        .gain_sample(gain_sample), .gain_req(gain_req), .gain_done(gain_done),
        .pipe_tick(pipe_tick), .pipe_ready(pipe_ready), .pipe_active(pipe_active),
        .mix_req(mix_req), .mix_done(mix_done), .mix_sample(mix_sample),
        .out_sample(out_sample), .out_valid(out_valid), .ready(ready),
        .clear_stats(clear_stats), .sample_count(sample_count),
        .overrun_count(overrun_count), .timeout(timeout), .timed_out_mask(timed_out_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_env();
        gain_wait = 0; mix_wait = 0; spur = 0; sr_with_mix = 0;
        for (int i = 0; i < NP; i++) begin pipe_busy[i] = 0; pipe_lat[i] = 0; end
        pipe_stuck = '0; pipe_active = '1; gain_lat = 1; mix_lat = 1;
        m_busy = 0; m_gained = 0; m_samples = 0; m_ovr = 0; m_out = '0;
        exp_gain_req = 0; exp_out_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; sample_ready = 0; gain_done = 0; mix_done = 0; clear_stats = 0;
        pipe_ready = '1;
        clear_env();
        repeat (2) step();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock: responders pick inputs, model advances, edge happens
    task automatic cycle(input logic sr, input logic clr, input logic [DW-1:0] din);
        bit busy_now;
        gain_done = spur;
        mix_done  = spur;
        if (gain_wait > 0) begin gain_wait--; if (gain_wait == 0) gain_done = 1'b1; end
        if (mix_wait > 0)  begin mix_wait--;  if (mix_wait == 0)  mix_done  = 1'b1; end
        mix_sample = next_mix;
        for (int i = 0; i < NP; i++) begin
            pipe_ready[i] = (pipe_busy[i] == 0) && !pipe_stuck[i];
            if (pipe_busy[i] > 0) pipe_busy[i]--;
        end
        if (gain_req) gain_wait = gain_lat;
        if (mix_req)  mix_wait  = mix_lat;
        if (pipe_tick) for (int i = 0; i < NP; i++) pipe_busy[i] = pipe_lat[i];
        sample_ready = sr | (sr_with_mix & mix_done);
        in_sample    = din;
        clear_stats  = clr;

        busy_now = m_busy; exp_gain_req = 0; exp_out_valid = 0;
        if (sample_ready) begin
            if (!busy_now) begin m_busy = 1; m_gained = 0; exp_gain_req = 1; m_in = din; end
            else if (m_ovr < CMAX) m_ovr++;
        end
        if (gain_done && busy_now && !m_gained) begin m_gained = 1; m_samples++; end
        if (mix_done && busy_now && m_gained) begin m_busy = 0; exp_out_valid = 1; m_out = next_mix; end
        if (clr) begin m_samples = 0; m_ovr = 0; end
        step();
    endtask

    task automatic drain(output bit ok);
        int k = 0;
        while (m_busy && k < 100) begin cycle(1'b0, 1'b0, '0); k++; end
        ok = !m_busy;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        vectors++; if ({gain_req, pipe_tick, mix_req, out_valid, timeout} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 00000", {gain_req, pipe_tick, mix_req, out_valid, timeout}); end
        vectors++; if ({gain_sample, out_sample} !== '0) begin
            errors++; $display("FAIL reset_data: got %h/%h want 0/0", gain_sample, out_sample); end
        vectors++; if ({sample_count, overrun_count, timed_out_mask} !== '0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d/%b want 0", sample_count, overrun_count, timed_out_mask); end
    endtask

    task automatic test_nominal();
        int  n;
        bit  ok;
        next_mix = 16'h0F00;
        cycle(1'b1, 1'b0, 16'h1234);
        n = 1;
        vectors++; if (gain_req !== 1'b1 || ready !== 1'b0 || gain_sample !== 16'h1234) begin
            errors++; $display("FAIL nominal_accept: req=%b ready=%b gs=%h want 1 0 1234", gain_req, ready, gain_sample); end
        while (!out_valid && n < 40) begin cycle(1'b0, 1'b0, '0); n++; end
        vectors++; if (n !== 7) begin errors++; $display("FAIL nominal_latency: got %0d want 7", n); end
        vectors++; if (out_sample !== 16'h0F00 || ready !== 1'b1) begin
            errors++; $display("FAIL nominal_output: got %h ready=%b want 0f00 1", out_sample, ready); end
        vectors++; if (sample_count !== 4'd1) begin errors++; $display("FAIL nominal_count: got %0d want 1", sample_count); end
        cycle(1'b1, 1'b0, 16'h5555);
        vectors++; if (gain_req !== 1'b1 || out_valid !== 1'b0 || gain_sample !== 16'h5555) begin
            errors++; $display("FAIL back_to_back: req=%b ov=%b gs=%h want 1 0 5555", gain_req, out_valid, gain_sample); end
        drain(ok);
        vectors++; if (!ok) begin errors++; $display("FAIL back_to_back_drain: stuck busy, want completion"); end
    endtask

    task automatic test_ignored_strobes();
        logic [CW-1:0] sc;
        sc = sample_count;
        spur = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, '0);
        spur = 1'b0;
        vectors++; if (sample_count !== sc || out_valid !== 1'b0 || ready !== 1'b1 || pipe_tick !== 1'b0) begin
            errors++; $display("FAIL ignored_strobes: sc=%0d ov=%b rdy=%b tick=%b want %0d 0 1 0", sample_count, out_valid, ready, pipe_tick, sc); end
    endtask

    task automatic test_masking();
        int n, exp_n;
        bit ok;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                pipe_active = 4'b0101; pipe_stuck = 4'b0010;
                pipe_lat[0] = 3; pipe_lat[1] = 0; pipe_lat[2] = 5; pipe_lat[3] = 0;
            end else if (k == 1) begin
                pipe_active = 4'b0000; pipe_stuck = 4'b1111;
            end else begin
                pipe_active = NP'($urandom);
                pipe_stuck  = ~pipe_active & NP'($urandom);
                for (int i = 0; i < NP; i++) pipe_lat[i] = $urandom_range(7, 0);
            end
            exp_n = 2;
            for (int i = 0; i < NP; i++)
                if (pipe_active[i] && 2 + pipe_lat[i] > exp_n) exp_n = 2 + pipe_lat[i];
            cycle(1'b1, 1'b0, DW'($urandom));
            n = 0;
            while (!pipe_tick && n < 20) begin cycle(1'b0, 1'b0, '0); n++; end
            n = 0;
            while (!mix_req && n < 40) begin cycle(1'b0, 1'b0, '0); n++; end
            vectors++; if (n !== exp_n) begin
                errors++; $display("FAIL masking_%0d: tick->mix_req %0d want %0d (active=%b)", k, n, exp_n, pipe_active); end
            cycle(1'b0, 1'b0, '0);
            vectors++; if (mix_req !== 1'b0) begin errors++; $display("FAIL mix_req_width_%0d: got 1 want 0", k); end
            drain(ok);
            vectors++; if (!ok) begin errors++; $display("FAIL masking_drain_%0d: stuck busy", k); end
        end
        pipe_stuck = '0; pipe_active = '1;
        for (int i = 0; i < NP; i++) pipe_lat[i] = 0;
    endtask

    task automatic test_overrun();
        int ovc = 0;
        cycle(1'b0, 1'b1, '0);
        pipe_lat[0] = 4;
        sr_with_mix = 1'b1;
        cycle(1'b1, 1'b0, 16'h0042);
        for (int n = 1; n < 20; n++) begin
            cycle((n == 5 || n == 6), 1'b0, 16'h0099);
            if (out_valid) ovc++;
        end
        sr_with_mix = 1'b0; pipe_lat[0] = 0;
        vectors++; if (overrun_count !== 4'd3 || m_ovr != 3) begin
            errors++; $display("FAIL overrun_count: got %0d (model %0d) want 3", overrun_count, m_ovr); end
        vectors++; if (ovc !== 1) begin errors++; $display("FAIL overrun_out_valid: got %0d want 1", ovc); end
    endtask

    task automatic test_sat_wrap_clear();
        bit ok;
        cycle(1'b0, 1'b1, '0);
        for (int n = 0; n < 60; n++) cycle(1'b1, 1'b0, DW'($urandom));
        drain(ok);
        vectors++; if (!ok || overrun_count !== 4'd15) begin
            errors++; $display("FAIL overrun_saturate: got %0d want 15", overrun_count); end
        vectors++; if (sample_count !== CW'(m_samples)) begin
            errors++; $display("FAIL hammer_samples: got %0d want %0d", sample_count, CW'(m_samples)); end
        cycle(1'b0, 1'b1, '0);
        for (int s = 0; s < 17; s++) begin
            cycle(1'b1, 1'b0, DW'($urandom));
            drain(ok);
        end
        vectors++; if (sample_count !== 4'd1) begin errors++; $display("FAIL sample_wrap: got %0d want 1", sample_count); end
        cycle(1'b1, 1'b0, 16'h0007);
        cycle(1'b1, 1'b1, 16'h0008);
        vectors++; if (overrun_count !== 4'd0 || sample_count !== 4'd0) begin
            errors++; $display("FAIL clear_vs_overrun: got %0d/%0d want 0/0", overrun_count, sample_count); end
        cycle(1'b0, 1'b1, '0);
        vectors++; if (sample_count !== 4'd0) begin errors++; $display("FAIL clear_vs_sample: got %0d want 0", sample_count); end
        drain(ok);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if (c % 97 == 0) begin
                gain_lat = $urandom_range(5, 1); mix_lat = $urandom_range(5, 1);
                for (int i = 0; i < NP; i++) pipe_lat[i] = $urandom_range(6, 0);
                pipe_active = NP'($urandom);
            end
            next_mix = DW'($urandom);
            cycle(($urandom_range(2, 0) == 0), ($urandom_range(49, 0) == 0), DW'($urandom));
            vectors++; if (ready !== !m_busy) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", c, ready, !m_busy); end
            vectors++; if (gain_req !== exp_gain_req || (exp_gain_req && gain_sample !== m_in)) begin
                errors++; $display("FAIL rnd_gain@%0d: req=%b gs=%h want %b %h", c, gain_req, gain_sample, exp_gain_req, m_in); end
            vectors++; if (out_valid !== exp_out_valid || out_sample !== m_out) begin
                errors++; $display("FAIL rnd_out@%0d: ov=%b os=%h want %b %h", c, out_valid, out_sample, exp_out_valid, m_out); end
            vectors++; if (sample_count !== CW'(m_samples) || overrun_count !== CW'(m_ovr)) begin
                errors++; $display("FAIL rnd_counters@%0d: got %0d/%0d want %0d/%0d", c, sample_count, overrun_count, CW'(m_samples), CW'(m_ovr)); end
            vectors++; if (timeout !== 1'b0) begin errors++; $display("FAIL rnd_timeout@%0d: got 1 want 0", c); end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int ovc = 0;
        pipe_stuck = '1; pipe_active = '1;
        cycle(1'b1, 1'b0, 16'h0A0A);
        repeat (6) cycle(1'b0, 1'b0, '0);
        #2 reset = 1'b0;
        #1;
        vectors++; if (ready !== 1'b1 || {gain_req, pipe_tick, mix_req, out_valid, timeout} !== 5'b0) begin
            errors++; $display("FAIL async_reset_outputs: ready=%b strobes=%b want 1 00000", ready, {gain_req, pipe_tick, mix_req, out_valid, timeout}); end
        vectors++; if (sample_count !== '0 || overrun_count !== '0) begin
            errors++; $display("FAIL async_reset_counters: got %0d/%0d want 0/0", sample_count, overrun_count); end
        step();
        @(negedge clk);
        reset = 1'b1;
        clear_env();
        repeat (4) begin cycle(1'b0, 1'b0, '0); if (out_valid) ovc++; end
        vectors++; if (ovc !== 0) begin errors++; $display("FAIL async_reset_discard: got %0d out_valid want 0", ovc); end
        next_mix = 16'h3C3C;
        cycle(1'b1, 1'b0, 16'h0B0B);
        vectors++; if (gain_req !== 1'b1 || gain_sample !== 16'h0B0B) begin
            errors++; $display("FAIL async_reset_accept: req=%b gs=%h want 1 0b0b", gain_req, gain_sample); end
        drain(ok);
        vectors++; if (!ok || out_sample !== 16'h3C3C) begin
            errors++; $display("FAIL async_reset_complete: got %h want 3c3c", out_sample); end
    endtask

    task automatic test_watchdog();
        int n;
        bit ok;
        do_reset();
        next_mix = 16'hBEEF;
        cycle(1'b1, 1'b0, 16'h0001);
        drain(ok);
        pipe_active = 4'b0011; pipe_stuck = 4'b0010; mix_lat = 0;
        cycle(1'b1, 1'b0, 16'h0002);
        n = 0;
        while (!pipe_tick && n < 20) begin cycle(1'b0, 1'b0, '0); n++; end
`ifdef ENGINE_SEQ_WATCHDOG_EN
        n = 0;
        while (!timeout && n < 60) begin cycle(1'b0, 1'b0, '0); n++; end
        vectors++; if (n !== TO + 1 || mix_req !== 1'b1 || timed_out_mask !== 4'b0010) begin
            errors++; $display("FAIL wd_wait: n=%0d mix_req=%b mask=%b want %0d 1 0010", n, mix_req, timed_out_mask, TO + 1); end
        n = 0;
        cycle(1'b0, 1'b0, '0);
        n = 1;
        while (!timeout && n < 60) begin
            if (out_valid) n = 100;
            cycle(1'b0, 1'b0, '0); n++;
        end
        vectors++; if (n !== TO || ready !== 1'b1 || out_valid !== 1'b0 || out_sample !== 16'hBEEF || timed_out_mask !== '0) begin
            errors++; $display("FAIL wd_mix: n=%0d rdy=%b ov=%b os=%h mask=%b want %0d 1 0 beef 0", n, ready, out_valid, out_sample, timed_out_mask, TO); end
`else
        n = 0;
        for (int c = 0; c < 3 * TO; c++) begin
            cycle(1'b0, 1'b0, '0);
            if (timeout !== 1'b0 || mix_req !== 1'b0 || timed_out_mask !== '0) n++;
        end
        vectors++; if (n !== 0 || ready !== 1'b0) begin
            errors++; $display("FAIL wd_disabled: %0d bad cycles ready=%b want 0 0", n, ready); end
`endif
        do_reset();
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin pipe_lat[i] = 0; pipe_busy[i] = 0; end
        test_reset();
        test_nominal();
        test_ignored_strobes();
        test_masking();
        test_overrun();
        test_sat_wrap_clear();
        test_random();
        test_async_reset();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
